// File: rtl/axil_pattern_checker.sv
// AXI4-Lite self-test master: writes a generated pattern to NUM_WORDS consecutive
// words, reads them back, and counts data mismatches plus non-OKAY responses.
module axil_pattern_checker #(
  parameter int unsigned              ADDR_WIDTH   = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              NUM_WORDS    = 4,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = '0,
  parameter logic [DATA_WIDTH-1:0]    SEED         = DATA_WIDTH'(1),
  parameter int unsigned              PATTERN_MODE = 0
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [15:0]                 error_count,
  output logic [ADDR_WIDTH-1:0]       first_err_addr,
  output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
  output logic [2:0]                  m_axil_awprot,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [DATA_WIDTH-1:0]       m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]     m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
  output logic [2:0]                  m_axil_arprot,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  localparam int unsigned           IDX_W     = 17;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] GEN_INIT  = (PATTERN_MODE == 2) ? DATA_WIDTH'(1) : SEED;
  localparam logic [31:0]           LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   gen;
  logic [DATA_WIDTH-1:0]   gen_next;
  logic [DATA_WIDTH-1:0]   pat_val;
  logic                    last_word;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    err_now;

  assign m_axil_awaddr = addr;
  assign m_axil_araddr = addr;
  assign m_axil_wdata  = pat_val;
  assign m_axil_awprot = '0;
  assign m_axil_arprot = '0;
  assign m_axil_wstrb  = '1;

  assign last_word = (idx == LAST_IDX);
  // A channel counts as done once its valid has dropped or is being accepted now
  assign aw_ok = !m_axil_awvalid || m_axil_awready;
  assign w_ok  = !m_axil_wvalid  || m_axil_wready;

  // gen holds the generator state for the current word; pat_val is the word value
  always_comb begin
    gen_next = gen;
    pat_val  = gen;
    case (PATTERN_MODE)
      1: begin
        gen_next[31:0] = {1'b0, gen[31:1]} ^ (gen[0] ? LFSR_POLY : 32'h0);
        pat_val        = {(DATA_WIDTH/32){gen[31:0]}};
      end
      2:       gen_next = {gen[DATA_WIDTH-2:0], gen[DATA_WIDTH-1]};
      default: gen_next = gen + DATA_WIDTH'(1);
    endcase
  end

  always_comb begin
    err_now = 1'b0;
    if (state == WR_RESP && m_axil_bvalid)
      err_now = (m_axil_bresp != 2'b00);
    else if (state == RD_RESP && m_axil_rvalid)
      err_now = (m_axil_rdata != pat_val) || (m_axil_rresp != 2'b00);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= IDLE;
      idx            <= '0;
      addr           <= '0;
      gen            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (err_now) begin
        if (error_count != '1) error_count <= error_count + 16'd1;
        if (error_count == '0) first_err_addr <= addr;
      end
      case (state)
        IDLE: begin
          if (start) begin
            error_count    <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            idx            <= '0;
            addr           <= BASE_ADDR;
            gen            <= GEN_INIT;
            busy           <= 1'b1;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            state          <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axil_bready <= 1'b1;
            state         <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            if (last_word) begin
              idx            <= '0;
              addr           <= BASE_ADDR;
              gen            <= GEN_INIT;
              m_axil_arvalid <= 1'b1;
              state          <= RD_REQ;
            end else begin
              idx            <= idx + IDX_W'(1);
              addr           <= addr + ADDR_STEP;
              gen            <= gen_next;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= WR_REQ;
            end
          end
        end
        RD_REQ: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            if (last_word) begin
              state <= FIN;
            end else begin
              idx            <= idx + IDX_W'(1);
              addr           <= addr + ADDR_STEP;
              gen            <= gen_next;
              m_axil_arvalid <= 1'b1;
              state          <= RD_REQ;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (error_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_pattern_checker.sv
// Bench for axil_pattern_checker: a default 32-bit instance against a configurable
// memory slave, plus a 64-bit LFSR instance against an ideal memory slave.
`timescale 1ns/1ps
module tb_axil_pattern_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: defaults ----------------
  logic        a_start = 1'b0;
  logic        a_busy, a_done, a_pass;
  logic [15:0] a_ec;
  logic [31:0] a_fea;
  logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
  logic [2:0]  a_awprot, a_arprot;
  logic [3:0]  a_wstrb;
  logic        a_awvalid, a_awready, a_wvalid, a_wready;
  logic [1:0]  a_bresp, a_rresp;
  logic        a_bvalid, a_bready, a_arvalid, a_arready, a_rvalid, a_rready;

  axil_pattern_checker dut_a (
    .ACLK(clk), .ARESETN(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .pass(a_pass), .error_count(a_ec), .first_err_addr(a_fea),
    .m_axil_awaddr(a_awaddr), .m_axil_awprot(a_awprot), .m_axil_awvalid(a_awvalid),
    .m_axil_awready(a_awready), .m_axil_wdata(a_wdata), .m_axil_wstrb(a_wstrb),
    .m_axil_wvalid(a_wvalid), .m_axil_wready(a_wready), .m_axil_bresp(a_bresp),
    .m_axil_bvalid(a_bvalid), .m_axil_bready(a_bready), .m_axil_araddr(a_araddr),
    .m_axil_arprot(a_arprot), .m_axil_arvalid(a_arvalid), .m_axil_arready(a_arready),
    .m_axil_rdata(a_rdata), .m_axil_rresp(a_rresp), .m_axil_rvalid(a_rvalid),
    .m_axil_rready(a_rready)
  );

  // slave A knobs
  int unsigned aw_dly = 0, w_dly = 0;
  bit          rnd_stall = 1'b0;
  bit          corrupt_en = 1'b0, werr_en = 1'b0;
  logic [31:0] corrupt_addr = '0, werr_addr = '0;

  // slave A state
  int unsigned aw_wait, w_wait, b_cnt, r_cnt;
  logic        got_aw, got_w, b_pend, r_pend;
  logic [31:0] aw_q, w_q, ar_q;
  logic [31:0] mem_a [16];
  logic [31:0] wr_addr_log [64];
  logic [31:0] wr_data_log [64];
  int          wr_n = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;

  assign a_awready = a_awvalid && (aw_wait >= aw_dly);
  assign a_wready  = a_wvalid && (w_wait >= w_dly);
  assign a_arready = a_arvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      a_bvalid <= 1'b0; a_rvalid <= 1'b0; a_bresp <= 2'b00; a_rresp <= 2'b00; a_rdata <= '0;
    end else begin
      aw_wait <= (a_awvalid && !a_awready) ? aw_wait + 1 : 0;
      w_wait  <= (a_wvalid && !a_wready) ? w_wait + 1 : 0;
      if (a_awvalid && a_awready) begin got_aw <= 1'b1; aw_q <= a_awaddr; aw_hs <= aw_hs + 1; end
      if (a_wvalid && a_wready) begin got_w <= 1'b1; w_q <= a_wdata; w_hs <= w_hs + 1; end
      if (got_aw && got_w && !b_pend && !a_bvalid) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        mem_a[aw_q[5:2]] <= w_q;
        wr_addr_log[wr_n % 64] <= aw_q;
        wr_data_log[wr_n % 64] <= w_q;
        wr_n <= wr_n + 1;
        b_pend <= 1'b1;
        b_cnt <= rnd_stall ? $urandom_range(3, 0) : 0;
        a_bresp <= (werr_en && aw_q == werr_addr) ? 2'b10 : 2'b00;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin a_bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (a_bvalid && a_bready) a_bvalid <= 1'b0;
      if (a_arvalid && a_arready) begin
        ar_q <= a_araddr; ar_hs <= ar_hs + 1; r_pend <= 1'b1;
        r_cnt <= rnd_stall ? $urandom_range(3, 0) : 0;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          a_rvalid <= 1'b1; r_pend <= 1'b0;
          a_rdata <= (corrupt_en && ar_q == corrupt_addr) ? 32'h0000_DEAD : mem_a[ar_q[5:2]];
        end else r_cnt <= r_cnt - 1;
      end
      if (a_rvalid && a_rready) a_rvalid <= 1'b0;
    end
  end

  // ---------------- instance X: 64-bit LFSR, 256 words ----------------
  logic        x_start = 1'b0;
  logic        x_busy, x_done, x_pass;
  logic [15:0] x_ec;
  logic [31:0] x_fea, x_awaddr, x_araddr;
  logic [63:0] x_wdata, x_rdata;
  logic [2:0]  x_awprot, x_arprot;
  logic [7:0]  x_wstrb;
  logic        x_awvalid, x_wvalid, x_bvalid, x_bready, x_arvalid, x_rvalid, x_rready;
  logic [1:0]  x_bresp, x_rresp;
  logic        x_awready, x_wready, x_arready;

  assign x_awready = 1'b1;
  assign x_wready  = 1'b1;
  assign x_arready = 1'b1;
  assign x_bresp   = 2'b00;
  assign x_rresp   = 2'b00;

  axil_pattern_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_WORDS(256),
    .BASE_ADDR(32'hFFFF_F800), .SEED(64'd1), .PATTERN_MODE(1)
  ) dut_x (
    .ACLK(clk), .ARESETN(rst_n), .start(x_start), .busy(x_busy), .done(x_done),
    .pass(x_pass), .error_count(x_ec), .first_err_addr(x_fea),
    .m_axil_awaddr(x_awaddr), .m_axil_awprot(x_awprot), .m_axil_awvalid(x_awvalid),
    .m_axil_awready(x_awready), .m_axil_wdata(x_wdata), .m_axil_wstrb(x_wstrb),
    .m_axil_wvalid(x_wvalid), .m_axil_wready(x_wready), .m_axil_bresp(x_bresp),
    .m_axil_bvalid(x_bvalid), .m_axil_bready(x_bready), .m_axil_araddr(x_araddr),
    .m_axil_arprot(x_arprot), .m_axil_arvalid(x_arvalid), .m_axil_arready(x_arready),
    .m_axil_rdata(x_rdata), .m_axil_rresp(x_rresp), .m_axil_rvalid(x_rvalid),
    .m_axil_rready(x_rready)
  );

  logic [63:0] mem_x [256];
  int          xw_n = 0;
  logic [31:0] x_first_addr = '0, x_last_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_bvalid <= 1'b0; x_rvalid <= 1'b0; x_rdata <= '0;
    end else begin
      if (x_awvalid && x_wvalid) begin
        mem_x[x_awaddr[10:3]] <= x_wdata;
        x_bvalid <= 1'b1;
        xw_n <= xw_n + 1;
        if (xw_n == 0) x_first_addr <= x_awaddr;
        x_last_addr <= x_awaddr;
      end
      if (x_bvalid && x_bready) x_bvalid <= 1'b0;
      if (x_arvalid) begin x_rvalid <= 1'b1; x_rdata <= mem_x[x_araddr[10:3]]; end
      if (x_rvalid && x_rready) x_rvalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic run_a(output bit ok);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (a_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", a_pass); end
    checks++; if (a_ec !== 16'd0) begin errors++; $display("FAIL reset_ec: got %0d want 0", a_ec); end
    checks++; if (a_fea !== 32'd0) begin errors++; $display("FAIL reset_fea: got %h want 0", a_fea); end
    checks++;
    if ({a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 00000",
                         {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (a_awvalid !== 1'b0) begin errors++; $display("FAIL idle_no_start: awvalid %b want 0", a_awvalid); end
  endtask

  task automatic test_ideal();
    bit ok;
    int base = wr_n;
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_d = '{32'd1, 32'd2, 32'd3, 32'd4};
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", a_busy); end
    checks++; if (a_awvalid !== 1'b1 || a_wvalid !== 1'b1) begin
      errors++; $display("FAIL aw_w_raise: aw %b w %b want 1 1", a_awvalid, a_wvalid); end
    checks++; if (a_wstrb !== 4'hF || a_awprot !== 3'd0) begin
      errors++; $display("FAIL strb_prot: wstrb %h awprot %0d want f 0", a_wstrb, a_awprot); end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (a_arvalid === 1'b1) begin
        if (a_arprot !== 3'd0) begin errors++; $display("FAIL arprot: got %0d want 0", a_arprot); end
      end
      if (a_done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ideal_done: timeout got 0 want 1"); end
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b want 1", a_pass); end
    checks++; if (a_ec !== 16'd0) begin errors++; $display("FAIL ideal_ec: got %0d want 0", a_ec); end
    checks++; if (a_fea !== 32'd0) begin errors++; $display("FAIL ideal_fea: got %h want 0", a_fea); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ideal_busy: got %b want 0", a_busy); end
    checks++; if (wr_n - base != 4) begin errors++; $display("FAIL ideal_wcount: got %0d want 4", wr_n - base); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_addr_log[(base + k) % 64] !== exp_a[k] || wr_data_log[(base + k) % 64] !== exp_d[k]) begin
        errors++; $display("FAIL ideal_write%0d: got %h@%h want %h@%h", k,
          wr_data_log[(base + k) % 64], wr_addr_log[(base + k) % 64], exp_d[k], exp_a[k]);
      end
    end
    @(negedge clk);
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", a_done); end
    repeat (3) @(negedge clk);
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL pass_held: got %b want 1", a_pass); end
  endtask

  task automatic test_corrupt_read();
    bit ok;
    corrupt_en = 1'b1; corrupt_addr = 32'h8;
    run_a(ok);
    corrupt_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL corrupt_done: timeout got 0 want 1"); end
    checks++; if (a_ec !== 16'd1) begin errors++; $display("FAIL corrupt_ec: got %0d want 1", a_ec); end
    checks++; if (a_fea !== 32'h8) begin errors++; $display("FAIL corrupt_fea: got %h want 8", a_fea); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b want 0", a_pass); end
  endtask

  task automatic test_write_error();
    bit ok;
    werr_en = 1'b1; werr_addr = 32'h4;
    corrupt_en = 1'b1; corrupt_addr = 32'h4;
    run_a(ok);
    werr_en = 1'b0; corrupt_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL werr_done: timeout got 0 want 1"); end
    checks++; if (a_ec !== 16'd2) begin errors++; $display("FAIL werr_ec: got %0d want 2", a_ec); end
    checks++; if (a_fea !== 32'h4) begin errors++; $display("FAIL werr_fea: got %h want 4", a_fea); end
    checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL werr_pass: got %b want 0", a_pass); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int aw0 = aw_hs, w0 = w_hs, ar0 = ar_hs;
    aw_dly = 3; w_dly = 1; rnd_stall = 1'b1;
    run_a(ok);
    aw_dly = 0; w_dly = 0; rnd_stall = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_done: timeout got 0 want 1"); end
    checks++; if (aw_hs - aw0 != 4) begin errors++; $display("FAIL bp_aw_count: got %0d want 4", aw_hs - aw0); end
    checks++; if (w_hs - w0 != 4) begin errors++; $display("FAIL bp_w_count: got %0d want 4", w_hs - w0); end
    checks++; if (ar_hs - ar0 != 4) begin errors++; $display("FAIL bp_ar_count: got %0d want 4", ar_hs - ar0); end
    checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL bp_pass: got %b want 1", a_pass); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int aw0 = aw_hs;
    int dones = 0;
    // previous pass left pass=1; a failing pass first, then a clean one must clear the counters
    corrupt_en = 1'b1; corrupt_addr = 32'hC;
    run_a(ok);
    corrupt_en = 1'b0;
    checks++; if (!ok || a_ec !== 16'd1 || a_fea !== 32'hC) begin
      errors++; $display("FAIL b2b_first: done %b ec %0d fea %h want 1 1 c", ok, a_ec, a_fea); end
    aw0 = aw_hs;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (6) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (a_done === 1'b1) begin dones++; ok = 1'b1; end
      if (ok && a_done !== 1'b1 && i > 200) break;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    checks++; if (aw_hs - aw0 != 4) begin errors++; $display("FAIL b2b_aw_count: got %0d want 4", aw_hs - aw0); end
    checks++; if (a_ec !== 16'd0 || a_fea !== 32'd0 || a_pass !== 1'b1) begin
      errors++; $display("FAIL b2b_cleared: ec %0d fea %h pass %b want 0 0 1", a_ec, a_fea, a_pass); end
  endtask

  task automatic test_reset_midpass();
    bit ok;
    bit seen = 1'b0;
    int aw0 = aw_hs;
    int aw_at_rst;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (a_awvalid === 1'b1 && a_awaddr === 32'h8) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_word2: timeout got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_awvalid, a_wvalid, a_arvalid, a_bready, a_rready, a_busy} !== 6'b0) begin
      errors++; $display("FAIL rst_abort: got %b want 000000",
                         {a_awvalid, a_wvalid, a_arvalid, a_bready, a_rready, a_busy});
    end
    checks++; if (aw_hs - aw0 != 2) begin errors++; $display("FAIL rst_aw_before: got %0d want 2", aw_hs - aw0); end
    aw_at_rst = aw_hs;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (aw_hs != aw_at_rst || a_awvalid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: new aw %0d awvalid %b busy %b want 0 0 0",
                         aw_hs - aw_at_rst, a_awvalid, a_busy); end
    run_a(ok);
    checks++; if (!ok || a_pass !== 1'b1 || a_ec !== 16'd0) begin
      errors++; $display("FAIL rst_recover: done %b pass %b ec %0d want 1 1 0", ok, a_pass, a_ec); end
  endtask

  task automatic test_wide_lfsr();
    bit ok = 1'b0;
    int bad = 0;
    logic [31:0] s = 32'd1;
    @(negedge clk); x_start = 1'b1;
    @(negedge clk); x_start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (x_done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL wide_done: timeout got 0 want 1"); end
    checks++; if (x_pass !== 1'b1 || x_ec !== 16'd0) begin
      errors++; $display("FAIL wide_pass: pass %b ec %0d want 1 0", x_pass, x_ec); end
    checks++; if (xw_n != 256) begin errors++; $display("FAIL wide_wcount: got %0d want 256", xw_n); end
    checks++; if (x_first_addr !== 32'hFFFF_F800 || x_last_addr !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL wide_addr: first %h last %h want fffff800 fffffff8", x_first_addr, x_last_addr); end
    for (int k = 0; k < 256; k++) begin
      if (mem_x[k] !== {s, s}) bad++;
      s = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wide_lfsr_data: got %0d bad words want 0", bad); end
    checks++; if (x_wstrb !== 8'hFF) begin errors++; $display("FAIL wide_wstrb: got %h want ff", x_wstrb); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_corrupt_read();
    test_write_error();
    test_backpressure();
    test_back_to_back();
    test_reset_midpass();
    test_wide_lfsr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
